// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, sequencer states, bus/ALU select codes and flag indices.
// Build option: CPU_CTRL_ILLEGAL_HALT_EN adds the HALT state (unknown opcodes stop the CPU).
package cpu_pkg;
    localparam logic [7:0] OP_LDA_IMM = 8'h86, OP_LDA_DIR = 8'h87, OP_LDB_IMM = 8'h88, OP_LDB_DIR = 8'h89;
    localparam logic [7:0] OP_STA_DIR = 8'h96, OP_STB_DIR = 8'h97;
    localparam logic [7:0] OP_ADD_AB = 8'h42, OP_SUB_AB = 8'h43, OP_AND_AB = 8'h44, OP_OR_AB = 8'h45;
    localparam logic [7:0] OP_INCA = 8'h46, OP_DECA = 8'h47, OP_INCB = 8'h48, OP_DECB = 8'h49;
    localparam logic [7:0] OP_BRA = 8'h20, OP_BMI = 8'h21, OP_BPL = 8'h22, OP_BEQ = 8'h23, OP_BNE = 8'h24;
    localparam logic [7:0] OP_BVS = 8'h25, OP_BVC = 8'h26, OP_BCS = 8'h27, OP_BCC = 8'h28;
    localparam logic [1:0] BUS1_PC = 2'b00, BUS1_A = 2'b01, BUS1_B = 2'b10;
    localparam logic [1:0] BUS2_ALU = 2'b00, BUS2_BUS1 = 2'b01, BUS2_MEM = 2'b10;
    localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR = 3'b011;
    localparam logic [2:0] ALU_INCA = 3'b100, ALU_DECA = 3'b101, ALU_INCB = 3'b110, ALU_DECB = 3'b111;
    localparam int CCR_N = 3, CCR_Z = 2, CCR_V = 1, CCR_C = 0;
    // E4..E8 are shared by loads and stores; the IR picks the variant inside them.
    typedef enum logic [3:0] {
        S_F0, S_F1, S_F2, S_D3, S_E4, S_E5, S_E6, S_E7, S_E8, S_ALU, S_BR4, S_BR5, S_BR6, S_BRN
`ifdef CPU_CTRL_ILLEGAL_HALT_EN
        , S_HALT
`endif
    } state_t;
    typedef struct packed {
        logic       ir_load;
        logic       mar_load;
        logic       pc_load;
        logic       pc_inc;
        logic       a_load;
        logic       b_load;
        logic       ccr_load;
        logic [1:0] bus1_sel;
        logic [1:0] bus2_sel;
        logic [2:0] alu_sel;
        logic       mem_write;
`ifdef CPU_CTRL_ILLEGAL_HALT_EN
        logic       halted;
`endif
    } ctl_t;
    function automatic logic is_ld_imm(input logic [7:0] op);
        return op == OP_LDA_IMM || op == OP_LDB_IMM;
    endfunction
    function automatic logic is_ld_dir(input logic [7:0] op);
        return op == OP_LDA_DIR || op == OP_LDB_DIR;
    endfunction
    function automatic logic is_st(input logic [7:0] op);
        return op == OP_STA_DIR || op == OP_STB_DIR;
    endfunction
    function automatic logic is_alu(input logic [7:0] op);
        return op >= OP_ADD_AB && op <= OP_DECB;
    endfunction
    function automatic logic is_br(input logic [7:0] op);
        return op >= OP_BRA && op <= OP_BCC;
    endfunction
    function automatic logic uses_b(input logic [7:0] op);
        return op == OP_LDB_IMM || op == OP_LDB_DIR || op == OP_STB_DIR || op == OP_INCB || op == OP_DECB;
    endfunction
    // ALU codes run in the same order as opcodes 42..49.
    function automatic logic [2:0] alu_of(input logic [7:0] op);
        logic [7:0] d;
        d = op - OP_ADD_AB;
        return d[2:0];
    endfunction
endpackage

// File: rtl/cpu_branch_eval.sv
// cpu_branch_eval: branch condition decode.
// Ports: opcode (IR), ccr (N Z V C) in; take out, high only for a branch whose condition holds.
module cpu_branch_eval
    import cpu_pkg::*;
(
    input  logic [7:0] opcode,
    input  logic [3:0] ccr,
    output logic       take
);
    always_comb begin
        case (opcode)
            OP_BRA:  take = 1'b1;
            OP_BMI:  take = ccr[CCR_N];
            OP_BPL:  take = !ccr[CCR_N];
            OP_BEQ:  take = ccr[CCR_Z];
            OP_BNE:  take = !ccr[CCR_Z];
            OP_BVS:  take = ccr[CCR_V];
            OP_BVC:  take = !ccr[CCR_V];
            OP_BCS:  take = ccr[CCR_C];
            OP_BCC:  take = !ccr[CCR_C];
            default: take = 1'b0;
        endcase
    end
endmodule

// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Ports: clk, reset (async, active-low), ir (opcode), ccr (N Z V C) in;
//        register strobes, bus1_sel/bus2_sel, alu_sel, mem_write, halted out (all registered).
// Build option: CPU_CTRL_ILLEGAL_HALT_EN makes unknown opcodes enter HALT instead of acting as NOP.
module cpu_control_fsm
    import cpu_pkg::*;
#(
    parameter int ALU_SEL_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           ir,
    input  logic [3:0]           ccr,
    output logic                 ir_load,
    output logic                 mar_load,
    output logic                 pc_load,
    output logic                 pc_inc,
    output logic                 a_load,
    output logic                 b_load,
    output logic                 ccr_load,
    output logic [1:0]           bus1_sel,
    output logic [1:0]           bus2_sel,
    output logic [ALU_SEL_W-1:0] alu_sel,
    output logic                 mem_write,
    output logic                 halted
);
`ifdef CPU_CTRL_ILLEGAL_HALT_EN
    localparam state_t S_ILLEGAL = S_HALT;
`else
    localparam state_t S_ILLEGAL = S_F0;
`endif
    state_t state, nxt;
    ctl_t   ctl_q;
    logic   run, take;
    cpu_branch_eval u_branch (
        .opcode(ir),
        .ccr   (ccr),
        .take  (take)
    );
    function automatic ctl_t ctl_of(input state_t s, input logic [7:0] op);
        ctl_t c;
        logic b;
        c = '0;
        b = uses_b(op);
        case (s)
            S_F0, S_E4, S_BR4: begin
                c.mar_load = 1'b1;
                c.bus2_sel = BUS2_BUS1;
            end
            S_F1, S_E5, S_BRN: c.pc_inc = 1'b1;
            S_F2: begin
                c.bus2_sel = BUS2_MEM;
                c.ir_load  = 1'b1;
            end
            S_E6: begin
                c.bus2_sel = BUS2_MEM;
                c.mar_load = !is_ld_imm(op);
                c.a_load   = is_ld_imm(op) && !b;
                c.b_load   = is_ld_imm(op) && b;
            end
            S_E7: begin
                c.bus1_sel  = !is_st(op) ? BUS1_PC : b ? BUS1_B : BUS1_A;
                c.mem_write = is_st(op);
            end
            S_E8: begin
                c.bus2_sel = BUS2_MEM;
                c.a_load   = !b;
                c.b_load   = b;
            end
            S_ALU: begin
                c.alu_sel  = alu_of(op);
                c.bus2_sel = BUS2_ALU;
                c.a_load   = !b;
                c.b_load   = b;
                c.ccr_load = 1'b1;
            end
            S_BR6: begin
                c.bus2_sel = BUS2_MEM;
                c.pc_load  = 1'b1;
            end
`ifdef CPU_CTRL_ILLEGAL_HALT_EN
            S_HALT: c.halted = 1'b1;
`endif
            default: ;
        endcase
        return c;
    endfunction
    // The first edge after reset only presents F0's strobes, so F0 is held one extra edge.
    always_comb begin
        nxt = S_F0;
        case (state)
            S_F0:  nxt = S_F1;
            S_F1:  nxt = S_F2;
            S_F2:  nxt = S_D3;
            S_D3:  nxt = (is_ld_imm(ir) || is_ld_dir(ir) || is_st(ir)) ? S_E4
                       : is_alu(ir) ? S_ALU
                       : is_br(ir) ? (take ? S_BR4 : S_BRN)
                       : S_ILLEGAL;
            S_E4:  nxt = S_E5;
            S_E5:  nxt = S_E6;
            S_E6:  nxt = is_ld_imm(ir) ? S_F0 : S_E7;
            S_E7:  nxt = is_ld_dir(ir) ? S_E8 : S_F0;
            S_BR4: nxt = S_BR5;
            S_BR5: nxt = S_BR6;
`ifdef CPU_CTRL_ILLEGAL_HALT_EN
            S_HALT: nxt = S_HALT;
`endif
            default: nxt = S_F0;
        endcase
        if (!run) nxt = S_F0;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_F0;
            ctl_q <= '0;
            run   <= 1'b0;
        end else begin
            state <= nxt;
            ctl_q <= ctl_of(nxt, ir);
            run   <= 1'b1;
        end
    end
    assign ir_load   = ctl_q.ir_load;
    assign mar_load  = ctl_q.mar_load;
    assign pc_load   = ctl_q.pc_load;
    assign pc_inc    = ctl_q.pc_inc;
    assign a_load    = ctl_q.a_load;
    assign b_load    = ctl_q.b_load;
    assign ccr_load  = ctl_q.ccr_load;
    assign bus1_sel  = ctl_q.bus1_sel;
    assign bus2_sel  = ctl_q.bus2_sel;
    assign alu_sel   = ALU_SEL_W'(ctl_q.alu_sel);
    assign mem_write = ctl_q.mem_write;
`ifdef CPU_CTRL_ILLEGAL_HALT_EN
    assign halted    = ctl_q.halted;
`else
    assign halted    = 1'b0;
`endif
endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb_cpu_control_fsm: drives the sequencer through a small datapath/memory harness and checks it against an ISA-level model.
module tb_cpu_control_fsm;
    logic       clk = 1'b0, reset = 1'b0;
    logic [7:0] ir;
    logic [3:0] ccr;
    logic       ir_load, mar_load, pc_load, pc_inc, a_load, b_load, ccr_load, mem_write, halted;
    logic [1:0] bus1_sel, bus2_sel;
    logic [2:0] alu_sel;

    cpu_control_fsm dut (
        .clk(clk), .reset(reset), .ir(ir), .ccr(ccr),
        .ir_load(ir_load), .mar_load(mar_load), .pc_load(pc_load), .pc_inc(pc_inc),
        .a_load(a_load), .b_load(b_load), .ccr_load(ccr_load),
        .bus1_sel(bus1_sel), .bus2_sel(bus2_sel), .alu_sel(alu_sel),
        .mem_write(mem_write), .halted(halted)
    );

    always #5 clk = ~clk;

    logic [7:0]  img [256];
    logic [7:0]  mem [256];
    logic [7:0]  mm  [256];
    logic [7:0]  pc_r, mar_r, ir_r, a_r, b_r, rdata, bus1, bus2;
    logic [3:0]  ccr_r;
    logic [11:0] alu_o;
    int cyc = 0, wr_cnt = 0, viol = 0, checks = 0, errors = 0;
    logic [7:0] optab [23] = '{8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46,
                               8'h47, 8'h48, 8'h49, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};

    wire [15:0] ctl   = {ir_load, mar_load, pc_load, pc_inc, a_load, b_load, ccr_load,
                         bus1_sel, bus2_sel, alu_sel, mem_write, halted};
    wire [5:0]  f0pat = {mar_load, bus1_sel, bus2_sel, pc_inc};

    // Datapath ALU: returns {N, Z, V, C, result}.
    function automatic logic [11:0] alu_fn(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] w;
        logic v;
        v = 1'b0;
        case (s)
            3'd0: begin w = {1'b0, a} + {1'b0, b}; v = (a[7] == b[7]) && (w[7] != a[7]); end
            3'd1: begin w = {1'b0, a} - {1'b0, b}; v = (a[7] != b[7]) && (w[7] != a[7]); end
            3'd2: w = {1'b0, a & b};
            3'd3: w = {1'b0, a | b};
            3'd4: begin w = {1'b0, a} + 9'd1; v = a == 8'h7f; end
            3'd5: begin w = {1'b0, a} - 9'd1; v = a == 8'h80; end
            3'd6: begin w = {1'b0, b} + 9'd1; v = b == 8'h7f; end
            default: begin w = {1'b0, b} - 9'd1; v = b == 8'h80; end
        endcase
        return {w[7], w[7:0] == 8'h00, v, w[8], w[7:0]};
    endfunction

    assign ir    = ir_r;
    assign ccr   = ccr_r;
    assign alu_o = alu_fn(alu_sel, a_r, b_r);
    always_comb bus1 = bus1_sel == 2'b01 ? a_r : bus1_sel == 2'b10 ? b_r : pc_r;
    always_comb bus2 = bus2_sel == 2'b00 ? alu_o[7:0] : bus2_sel == 2'b01 ? bus1 : rdata;

    // Datapath and synchronous memory harness steered only by the DUT strobes.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r <= 8'h00; mar_r <= 8'h00; ir_r <= 8'h00; a_r <= 8'h00; b_r <= 8'h00;
            ccr_r <= 4'h0; rdata <= 8'h00; mem <= img;
        end else begin
            rdata <= mem[mar_r];
            if (mar_load) mar_r <= bus2;
            if (ir_load) ir_r <= bus2;
            if (pc_load) pc_r <= bus2;
            else if (pc_inc) pc_r <= pc_r + 8'd1;
            if (a_load) a_r <= bus2;
            if (b_load) b_r <= bus2;
            if (ccr_load) ccr_r <= alu_o[11:8];
            if (mem_write) mem[mar_r] <= bus1;
        end
    end

    always @(posedge clk or negedge reset) cyc <= !reset ? 0 : cyc + 1;
    always @(posedge clk) begin
        if (reset && mem_write) wr_cnt <= wr_cnt + 1;
        if (pc_load && pc_inc) viol <= viol + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic run_random();
        logic [7:0]  ops [20];
        int          ad [21];
        int          n, e, t, lat, w0, nst, steps;
        logic [7:0]  mpc, ma, mb, op, opd, d;
        logic [3:0]  mf;
        logic [11:0] r;
        logic        tk;
        n = $urandom_range(8, 20);
        img = '{default: 8'h00};
        for (int a = 8'h80; a < 8'ha0; a++) img[a] = 8'($urandom);
        ad[0] = 0;
        for (int i = 0; i < n; i++) begin
            ops[i] = optab[$urandom_range(0, 22)];
            ad[i+1] = ad[i] + ((ops[i] >= 8'h42 && ops[i] <= 8'h49) ? 1 : 2);
        end
        for (int i = 0; i < n; i++) begin
            op = ops[i];
            img[ad[i]] = op;
            if (op <= 8'h28) img[ad[i]+1] = 8'(ad[(i + 2 <= n) ? i + 1 + $urandom_range(0, 1) : i + 1]);
            else if (op == 8'h86 || op == 8'h88) img[ad[i]+1] = 8'($urandom);
            else if (op >= 8'h87) img[ad[i]+1] = 8'h80 + 8'($urandom_range(0, 31));
        end
        e = ad[n];
        mm = img;
        mpc = 8'h00; ma = 8'h00; mb = 8'h00; mf = 4'h0; nst = 0; steps = 0;
        w0 = wr_cnt;
        do_reset();
        t = 1;
        while (int'(mpc) != e && steps < 40) begin
            wait_cyc(t);
            chk("rnd_f0", f0pat, 6'b100010);
            chk("rnd_pc", pc_r, mpc);
            chk("rnd_a", a_r, ma);
            chk("rnd_b", b_r, mb);
            chk("rnd_ccr", ccr_r, mf);
            op = mm[mpc];
            opd = mm[8'(mpc + 8'd1)];
            if (op == 8'h86 || op == 8'h88) begin
                if (op == 8'h86) ma = opd; else mb = opd;
                mpc += 8'd2; lat = 7;
            end else if (op == 8'h87 || op == 8'h89) begin
                if (op == 8'h87) ma = mm[opd]; else mb = mm[opd];
                mpc += 8'd2; lat = 9;
            end else if (op == 8'h96 || op == 8'h97) begin
                mm[opd] = op == 8'h96 ? ma : mb;
                nst++; mpc += 8'd2; lat = 8;
            end else if (op >= 8'h42 && op <= 8'h49) begin
                d = op - 8'h42;
                r = alu_fn(d[2:0], ma, mb);
                mf = r[11:8];
                if (op >= 8'h48) mb = r[7:0]; else ma = r[7:0];
                mpc += 8'd1; lat = 5;
            end else if (op >= 8'h20 && op <= 8'h28) begin
                case (op)
                    8'h20:   tk = 1'b1;
                    8'h21:   tk = mf[3];
                    8'h22:   tk = !mf[3];
                    8'h23:   tk = mf[2];
                    8'h24:   tk = !mf[2];
                    8'h25:   tk = mf[1];
                    8'h26:   tk = !mf[1];
                    8'h27:   tk = mf[0];
                    default: tk = !mf[0];
                endcase
                mpc = tk ? opd : mpc + 8'd2;
                lat = tk ? 7 : 5;
            end else begin
                mpc += 8'd1; lat = 4;
            end
            t += lat;
            steps++;
        end
        wait_cyc(t);
        chk("rnd_end_f0", f0pat, 6'b100010);
        chk("rnd_end_pc", pc_r, mpc);
        chk("rnd_end_a", a_r, ma);
        chk("rnd_end_b", b_r, mb);
        chk("rnd_writes", wr_cnt - w0, nst);
        for (int a = 8'h80; a < 8'ha0; a++) chk("rnd_mem", mem[a], mm[a]);
    endtask

    initial begin
        int w0;
        img = '{default: 8'h00};
        #3;
        chk("reset_ctl", ctl, 16'h0000);
        img[0] = 8'h86; img[1] = 8'hAA;
        do_reset();
        wait_cyc(1);
        chk("first_f0", f0pat, 6'b100010);
        wait_cyc(7);
        chk("ldai_e6", {a_load, b_load, bus2_sel}, 4'b1010);
        wait_cyc(8);
        chk("ldai_next_pc", pc_r, 8'h02);
        chk("ldai_a", a_r, 8'hAA);
        img = '{default: 8'h00};
        img[0] = 8'h87; img[1] = 8'h80; img[8'h80] = 8'h5C;
        do_reset();
        wait_cyc(7);
        chk("ldad_e6", {mar_load, bus2_sel}, 3'b110);
        wait_cyc(9);
        chk("ldad_e8", {a_load, bus2_sel}, 3'b110);
        wait_cyc(10);
        chk("ldad_a", a_r, 8'h5C);
        img = '{default: 8'h00};
        img[0] = 8'h86; img[1] = 8'h3C; img[2] = 8'h96; img[3] = 8'h90;
        w0 = wr_cnt;
        do_reset();
        wait_cyc(14);
        chk("sta_e6_nowrite", mem_write, 1'b0);
        wait_cyc(15);
        chk("sta_e7", {mem_write, bus1_sel}, 3'b101);
        wait_cyc(20);
        chk("sta_writes", wr_cnt - w0, 1);
        chk("sta_mem", mem[8'h90], 8'h3C);
        img = '{default: 8'h00};
        img[0] = 8'h42;
        do_reset();
        wait_cyc(5);
        chk("add_e4", {alu_sel, bus2_sel, a_load, b_load, ccr_load}, 8'b000_00_101);
        img[0] = 8'h48;
        do_reset();
        wait_cyc(5);
        chk("incb_e4", {alu_sel, bus2_sel, a_load, b_load, ccr_load}, 8'b110_00_011);
        img = '{default: 8'h00};
        img[0] = 8'h86; img[1] = 8'h01; img[2] = 8'h47; img[3] = 8'h23; img[4] = 8'h40;
        do_reset();
        wait_cyc(19);
        chk("beq_taken_e6", {pc_load, pc_inc, bus2_sel}, 4'b1010);
        wait_cyc(20);
        chk("beq_taken_f0", f0pat, 6'b100010);
        chk("beq_taken_pc", pc_r, 8'h40);
        img[1] = 8'h02;
        do_reset();
        wait_cyc(17);
        chk("beq_not_e4", {pc_load, pc_inc}, 2'b01);
        wait_cyc(18);
        chk("beq_not_f0", f0pat, 6'b100010);
        chk("beq_not_pc", pc_r, 8'h05);
        img = '{default: 8'h00};
        img[0] = 8'h87; img[1] = 8'h80; img[8'h80] = 8'h5C;
        do_reset();
        wait_cyc(6);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_ctl", ctl, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        wait_cyc(1);
        chk("abort_f0", f0pat, 6'b100010);
        chk("abort_pc", pc_r, 8'h00);
        wait_cyc(10);
        chk("abort_redo_a", a_r, 8'h5C);
        img = '{default: 8'h00};
        img[0] = 8'hFF; img[1] = 8'h86; img[2] = 8'h55;
        do_reset();
`ifdef CPU_CTRL_ILLEGAL_HALT_EN
        wait_cyc(5);
        chk("ill_halt", ctl, 16'h0001);
        wait_cyc(20);
        chk("ill_stay", ctl, 16'h0001);
`else
        wait_cyc(5);
        chk("ill_nop_f0", f0pat, 6'b100010);
        chk("ill_nop_pc", pc_r, 8'h01);
        chk("ill_halted", halted, 1'b0);
        wait_cyc(12);
        chk("ill_next_a", a_r, 8'h55);
`endif
        for (int p = 0; p < 10; p++) run_random();
        chk("pc_exclusive", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
